// File: rtl/mem_stage_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sram_ctrl_if
// Brief    : MEM-stage request/response bundle plus 16-bit async SRAM pins.
// Revision : 1.0  initial release
// ============================================================================
interface mem_stage_sram_ctrl_if #(
    parameter int unsigned SRAM_ADDR_W = 18
);
    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            alu_res;
    logic [31:0]            val_rm;
    logic                   ready;
    logic [31:0]            mem_result;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic                   sram_we_n;
    logic [15:0]            sram_dq_out;
    logic                   sram_dq_oe;
    logic [15:0]            sram_dq_in;

    // master: pipeline register plus the SRAM device; slave: the controller
    modport master (
        output mem_read, mem_write, alu_res, val_rm, sram_dq_in,
        input  ready, mem_result, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );

    modport slave (
        input  mem_read, mem_write, alu_res, val_rm, sram_dq_in,
        output ready, mem_result, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sram_ctrl
// Brief    : MEM-stage controller; splits 32-bit loads/stores into two 16-bit
//            async SRAM cycles and stalls the pipeline via ready.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage_sram_ctrl #(
    parameter int unsigned DATA_BASE     = 1024,
    parameter int unsigned SRAM_ADDR_W   = 18,
    parameter int unsigned ACCESS_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stage_sram_ctrl_if.slave  bus
);

    localparam bit                    c_HAS_PAD    = (ACCESS_CYCLES > 4);
    localparam int unsigned           c_PAD_CYCLES = c_HAS_PAD ? ACCESS_CYCLES - 4 : 1;
    localparam int unsigned           c_CNT_W      = (c_PAD_CYCLES > 1) ? $clog2(c_PAD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST   = c_CNT_W'(c_PAD_CYCLES - 1);
    localparam logic [SRAM_ADDR_W:0]  c_BASE       = (SRAM_ADDR_W + 1)'(DATA_BASE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_PAD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state,      w_state_nxt;
    logic [c_CNT_W-1:0]     r_pad_cnt,    w_pad_cnt_nxt;
    logic [31:0]            r_mem_result, w_mem_result_nxt;
    logic [SRAM_ADDR_W-1:0] r_sram_addr,  w_sram_addr_nxt;
    logic                   r_we_n,       w_we_n_nxt;
    logic [15:0]            r_dq_out,     w_dq_out_nxt;
    logic                   r_dq_oe,      w_dq_oe_nxt;
    logic                   w_ready;
    logic                   w_req;
    logic                   w_is_write;
    logic [SRAM_ADDR_W-2:0] w_word;

    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_is_write = bus.mem_write;

    // Word index of (alu_res - DATA_BASE); the low-bit borrow keeps unaligned bases exact.
    assign w_word = bus.alu_res[SRAM_ADDR_W:2] - c_BASE[SRAM_ADDR_W:2]
                  - {{(SRAM_ADDR_W-2){1'b0}}, (bus.alu_res[1:0] < c_BASE[1:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pad_cnt    <= '0;
            r_mem_result <= '0;
            r_sram_addr  <= '0;
            r_we_n       <= 1'b1;
            r_dq_out     <= '0;
            r_dq_oe      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pad_cnt    <= w_pad_cnt_nxt;
            r_mem_result <= w_mem_result_nxt;
            r_sram_addr  <= w_sram_addr_nxt;
            r_we_n       <= w_we_n_nxt;
            r_dq_out     <= w_dq_out_nxt;
            r_dq_oe      <= w_dq_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pad_cnt_nxt    = '0;
        w_mem_result_nxt = r_mem_result;
        w_sram_addr_nxt  = r_sram_addr;
        w_we_n_nxt       = 1'b1;
        w_dq_out_nxt     = r_dq_out;
        w_dq_oe_nxt      = 1'b0;
        w_ready          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = ~w_req;
                if (w_req) w_state_nxt = S_LO;
            end
            S_LO: begin
                if (!w_is_write) w_mem_result_nxt[15:0] = bus.sram_dq_in;
                w_state_nxt = S_HI;
            end
            S_HI: begin
                if (!w_is_write) w_mem_result_nxt[31:16] = bus.sram_dq_in;
                w_state_nxt = c_HAS_PAD ? S_PAD : S_DONE;
            end
            S_PAD: begin
                if (r_pad_cnt == c_CNT_LAST) w_state_nxt   = S_DONE;
                else                         w_pad_cnt_nxt = r_pad_cnt + 1'b1;
            end
            S_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // SRAM pins are registered, so they are set up for the state being entered.
        case (w_state_nxt)
            S_LO: begin
                w_sram_addr_nxt = {w_word, 1'b0};
                w_we_n_nxt      = ~w_is_write;
                w_dq_oe_nxt     = w_is_write;
                if (w_is_write) w_dq_out_nxt = bus.val_rm[15:0];
            end
            S_HI: begin
                w_sram_addr_nxt = {w_word, 1'b1};
                w_we_n_nxt      = ~w_is_write;
                w_dq_oe_nxt     = w_is_write;
                if (w_is_write) w_dq_out_nxt = bus.val_rm[31:16];
            end
            default: ;
        endcase
    end

    assign bus.ready       = w_ready;
    assign bus.mem_result  = r_mem_result;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_we_n   = r_we_n;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_sram_ctrl
// Brief    : Scoreboard bench for mem_stage_sram_ctrl (main at 6 cycles, sweep at 4 and 9).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) if_main ();
    mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) if_a4 ();
    mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) if_a9 ();

    mem_stage_sram_ctrl #(.DATA_BASE(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(6))
        u_dut_main (.clk(clk), .rst(rst), .bus(if_main));
    mem_stage_sram_ctrl #(.DATA_BASE(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(4))
        u_dut_a4 (.clk(clk), .rst(rst), .bus(if_a4));
    mem_stage_sram_ctrl #(.DATA_BASE(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(9))
        u_dut_a9 (.clk(clk), .rst(rst), .bus(if_a9));

    logic        drv_rd   [3];
    logic        drv_wr   [3];
    logic [31:0] drv_addr [3];
    logic [31:0] drv_data [3];

    assign if_main.mem_read  = drv_rd[0];
    assign if_main.mem_write = drv_wr[0];
    assign if_main.alu_res   = drv_addr[0];
    assign if_main.val_rm    = drv_data[0];
    assign if_a4.mem_read    = drv_rd[1];
    assign if_a4.mem_write   = drv_wr[1];
    assign if_a4.alu_res     = drv_addr[1];
    assign if_a4.val_rm      = drv_data[1];
    assign if_a4.sram_dq_in  = 16'h0000;
    assign if_a9.mem_read    = drv_rd[2];
    assign if_a9.mem_write   = drv_wr[2];
    assign if_a9.alu_res     = drv_addr[2];
    assign if_a9.val_rm      = drv_data[2];
    assign if_a9.sram_dq_in  = 16'h0000;

    // Small SRAM behind the main instance; reset reloads a known word at 4/5.
    logic [15:0] sram_mem [64];
    assign if_main.sram_dq_in = sram_mem[if_main.sram_addr[5:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= 16'h0000;
            sram_mem[4] <= 16'h1234;
            sram_mem[5] <= 16'hCAFE;
        end else if (!if_main.sram_we_n) begin
            sram_mem[if_main.sram_addr[5:0]] <= if_main.sram_dq_out;
        end
    end

    typedef struct packed { logic [17:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [31:0] result; int run; } done_t;

    wr_t   exp_wr   [$];
    done_t exp_done [$];
    int    exp_run4 [$];
    int    exp_run9 [$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Main monitor: compares every write strobe and every completed access.
    int    run_main = 0;
    wr_t   cur_wr;
    done_t cur_done;
    always @(negedge clk) begin
        if (rst) begin
            run_main = 0;
        end else begin
            if (!if_main.sram_we_n) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                             if_main.sram_addr, if_main.sram_dq_out);
                end else begin
                    cur_wr = exp_wr.pop_front();
                    check("wr_addr", 64'(if_main.sram_addr), 64'(cur_wr.addr));
                    check("wr_data", 64'(if_main.sram_dq_out), 64'(cur_wr.data));
                    check("wr_oe", 64'(if_main.sram_dq_oe), 64'd1);
                end
            end
            if (!if_main.ready) begin
                run_main++;
            end else if (run_main > 0) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got run %0d, expected none", run_main);
                end else begin
                    cur_done = exp_done.pop_front();
                    check("mem_result", 64'(if_main.mem_result), 64'(cur_done.result));
                    check("stall_run", 64'(run_main), 64'(cur_done.run));
                end
                run_main = 0;
            end
        end
    end

    // Sweep monitors: stall-run length and number of write strobes.
    int run4 = 0, run9 = 0, wcnt4 = 0, wcnt9 = 0;
    always @(negedge clk) begin
        if (rst) begin
            run4 = 0; run9 = 0;
        end else begin
            if (!if_a4.sram_we_n) wcnt4++;
            if (!if_a9.sram_we_n) wcnt9++;
            if (!if_a4.ready) run4++;
            else if (run4 > 0) begin
                if (exp_run4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a4_unexpected_done: got run %0d, expected none", run4);
                end else check("a4_stall_run", 64'(run4), 64'(exp_run4.pop_front()));
                run4 = 0;
            end
            if (!if_a9.ready) run9++;
            else if (run9 > 0) begin
                if (exp_run9.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a9_unexpected_done: got run %0d, expected none", run9);
                end else check("a9_stall_run", 64'(run9), 64'(exp_run9.pop_front()));
                run9 = 0;
            end
        end
    end

    function automatic logic rdy(input int k);
        if (k == 0) return if_main.ready;
        if (k == 1) return if_a4.ready;
        return if_a9.ready;
    endfunction

    // Presents a request and holds it until the DONE cycle has been clocked.
    task automatic issue(input int k, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        drv_rd[k] = rd; drv_wr[k] = wr; drv_addr[k] = a; drv_data[k] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(k) && n < 40);
        if (!rdy(k)) begin
            checks++; errors++;
            $display("FAIL timeout: ready stayed %0b, expected 1 within 40 cycles", rdy(k));
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k, input int n);
        drv_rd[k] = 1'b0; drv_wr[k] = 1'b0; drv_addr[k] = '0; drv_data[k] = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [17:0] lo, input logic [31:0] d);
        exp_wr.push_back('{addr: lo,        data: d[15:0]});
        exp_wr.push_back('{addr: lo + 18'd1, data: d[31:16]});
    endtask

    task automatic push_done(input logic [31:0] r, input int run);
        exp_done.push_back('{result: r, run: run});
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            drv_rd[k] = 1'b0; drv_wr[k] = 1'b0; drv_addr[k] = '0; drv_data[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",   64'(if_main.ready),       64'd1);
        check("rst_result",  64'(if_main.mem_result),  64'd0);
        check("rst_we_n",    64'(if_main.sram_we_n),   64'd1);
        check("rst_oe",      64'(if_main.sram_dq_oe),  64'd0);
        check("rst_addr",    64'(if_main.sram_addr),   64'd0);
        check("rst_dq_out",  64'(if_main.sram_dq_out), 64'd0);
        @(posedge clk); #1;

        // Store then back-to-back loads.
        push_write(18'd0, 32'hDEADBEEF); push_done(32'h0000_0000, 5);
        issue(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        push_done(32'hDEADBEEF, 5);
        issue(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        push_done(32'hCAFE1234, 5);
        issue(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        push_done(32'hDEADBEEF, 5);
        issue(0, 1'b1, 1'b0, 32'd1026, 32'h0);

        // Read+write together behaves as a write; result register untouched.
        push_write(18'd2, 32'h55AA33CC); push_done(32'hDEADBEEF, 5);
        issue(0, 1'b1, 1'b1, 32'd1028, 32'h55AA33CC);
        push_done(32'h55AA33CC, 5);
        issue(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle(0, 3);
        @(negedge clk);
        check("idle_ready",  64'(if_main.ready),      64'd1);
        check("idle_result", 64'(if_main.mem_result), 64'h55AA33CC);
        @(posedge clk); #1;

        // Abandon a read mid-flight with a 2-cycle reset.
        drv_rd[0] = 1'b1; drv_addr[0] = 32'd1032;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drv_rd[0] = 1'b0; drv_addr[0] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready",  64'(if_main.ready),      64'd1);
        check("mid_rst_result", 64'(if_main.mem_result), 64'd0);
        check("mid_rst_we_n",   64'(if_main.sram_we_n),  64'd1);
        check("mid_rst_oe",     64'(if_main.sram_dq_oe), 64'd0);
        check("mid_rst_addr",   64'(if_main.sram_addr),  64'd0);
        @(posedge clk); #1;
        push_done(32'hCAFE1234, 5);
        issue(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle(0, 2);

        // Access-length sweep.
        exp_run4.push_back(3); exp_run4.push_back(3);
        issue(1, 1'b0, 1'b1, 32'd1024, 32'h11112222);
        issue(1, 1'b0, 1'b1, 32'd1028, 32'h33334444);
        idle(1, 2);
        exp_run9.push_back(8); exp_run9.push_back(8);
        issue(2, 1'b0, 1'b1, 32'd1024, 32'h55556666);
        issue(2, 1'b0, 1'b1, 32'd1028, 32'h77778888);
        idle(2, 2);
        check("a4_write_strobes", 64'(wcnt4), 64'd4);
        check("a9_write_strobes", 64'(wcnt9), 64'd4);

        check("wr_queue_left",   64'(exp_wr.size()),   64'd0);
        check("done_queue_left", 64'(exp_done.size()), 64'd0);
        check("run4_queue_left", 64'(exp_run4.size()), 64'd0);
        check("run9_queue_left", 64'(exp_run9.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
